// File: rtl/booth_pp_accumulator_pkg.sv
// rtl/booth_pp_accumulator_pkg.sv - shared widths and partial-product alignment for the Booth multiplier
package booth_pp_accumulator_pkg;

  localparam int PP_WIDTH   = 10;
  localparam int PROD_WIDTH = 16;
  localparam int NUM_PP     = 4;

  function automatic int pp_shift(input int k);
    return 2 * k;
  endfunction

  // Sign-extend, apply the +1 negate correction, then place at weight 4^k.
  function automatic logic [PROD_WIDTH-1:0] pp_align(
    input logic [PP_WIDTH-1:0] pp,
    input logic                negate,
    input int                  k
  );
    logic [PROD_WIDTH-1:0] ext;
    ext = {{(PROD_WIDTH-PP_WIDTH){pp[PP_WIDTH-1]}}, pp};
    ext = ext + {{(PROD_WIDTH-1){1'b0}}, negate};
    return ext << pp_shift(k);
  endfunction

endpackage

// File: rtl/booth_pipe_reg.sv
// rtl/booth_pipe_reg.sv - valid/data pipeline register that loads only when its stage advances
module booth_pipe_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_data,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_data  <= '0;
    end else if (adv) begin
      q_valid <= d_valid;
      q_data  <= d_data;
    end
  end

endmodule

// File: rtl/booth_pp_accumulator.sv
// rtl/booth_pp_accumulator.sv - two-stage partial-product reduction with valid/ready flow control
module booth_pp_accumulator
  import booth_pp_accumulator_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PP_WIDTH-1:0]   partsum0,
  input  logic [PP_WIDTH-1:0]   partsum1,
  input  logic [PP_WIDTH-1:0]   partsum2,
  input  logic [PP_WIDTH-1:0]   partsum3,
  input  logic [NUM_PP-1:0]     neg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PROD_WIDTH-1:0] product
);

  logic                    v1, v2;
  logic                    s1_adv, s2_adv;
  logic [PROD_WIDTH-1:0]   sum01, sum23, s2_sum;
  logic [2*PROD_WIDTH-1:0] s1_d, s1_q;

  // Stall chain depends only on stage valids and out_ready, never on in_valid.
  assign s2_adv   = !v2 || out_ready;
  assign s1_adv   = !v1 || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    sum01 = pp_align(partsum0, neg[0], 0) + pp_align(partsum1, neg[1], 1);
    sum23 = pp_align(partsum2, neg[2], 2) + pp_align(partsum3, neg[3], 3);
    s1_d  = {sum01, sum23};
  end

  booth_pipe_reg #(.WIDTH(2*PROD_WIDTH)) u_s1 (
    .clk     (clk),
    .rst     (rst),
    .adv     (s1_adv),
    .d_valid (in_valid),
    .d_data  (s1_d),
    .q_valid (v1),
    .q_data  (s1_q)
  );

  assign s2_sum = s1_q[2*PROD_WIDTH-1:PROD_WIDTH] + s1_q[PROD_WIDTH-1:0];

  booth_pipe_reg #(.WIDTH(PROD_WIDTH)) u_s2 (
    .clk     (clk),
    .rst     (rst),
    .adv     (s2_adv),
    .d_valid (v1),
    .d_data  (s2_sum),
    .q_valid (v2),
    .q_data  (product)
  );

  assign out_valid = v2;

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// tb/tb_booth_pp_accumulator.sv - table-driven and scoreboard bench for booth_pp_accumulator
module tb_booth_pp_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [9:0]  partsum0 = '0, partsum1 = '0, partsum2 = '0, partsum3 = '0;
  logic [3:0]  neg = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] product;

  typedef struct {
    logic [9:0]  p0, p1, p2, p3;
    logic [3:0]  ng;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs [7];
  logic [15:0] exp_q [$];
  int          checks = 0;
  int          failures = 0;
  int          pops = 0;
  int          cycle = 0;
  int          pop_cycle [$];
  logic        accepted, first_try;

  booth_pp_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .partsum0  (partsum0),
    .partsum1  (partsum1),
    .partsum2  (partsum2),
    .partsum3  (partsum3),
    .neg       (neg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Scoreboard: a transfer happens at the next rising edge when valid && ready here.
  always @(negedge clk) begin
    cycle++;
    if (!rst && out_valid && out_ready) begin
      pops++;
      pop_cycle.push_back(cycle);
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {16'h0, product}, 32'hDEAD);
      end else begin
        chk("product_order", {16'h0, product}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic send(input vec_t v);
    @(posedge clk); #1;
    partsum0 = v.p0; partsum1 = v.p1; partsum2 = v.p2; partsum3 = v.p3; neg = v.ng;
    in_valid = 1'b1;
    accepted = 1'b0;
    first_try = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(v.exp);
        accepted = 1'b1;
        break;
      end
      first_try = 1'b0;
      @(posedge clk); #1;
    end
    if (!accepted) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{10'h003, 10'h003, 10'h000, 10'h000, 4'b0000, 16'h000F};
    vecs[1] = '{10'h3F8, 10'h000, 10'h000, 10'h000, 4'b0001, 16'hFFF9};
    vecs[2] = '{10'h000, 10'h000, 10'h000, 10'h0FF, 4'b1000, 16'h4000};
    vecs[3] = '{10'h000, 10'h000, 10'h000, 10'h000, 4'b0000, 16'h0000};
    vecs[4] = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 4'b1111, 16'h0000};
    vecs[5] = '{10'h1FF, 10'h200, 10'h001, 10'h000, 4'b0100, 16'hFA1F};
    vecs[6] = '{10'h000, 10'h000, 10'h1FF, 10'h1FF, 4'b1100, 16'hA000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", {31'h0, out_valid}, 0);
    chk("reset_product", {16'h0, product}, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", {31'h0, in_ready}, 1);

    // Latency: presented in cycle c, visible in cycle c+2.
    send(vecs[0]);
    idle();
    @(negedge clk);
    chk("lat_not_yet", {31'h0, out_valid}, 0);
    @(negedge clk);
    chk("lat_valid", {31'h0, out_valid}, 1);
    chk("lat_product", {16'h0, product}, 32'h000F);
    drain();

    // Back-to-back table stream with out_ready held high.
    pop_cycle.delete();
    for (int i = 0; i < 7; i++) begin
      send(vecs[i]);
      chk($sformatf("stream_in_ready_%0d", i), {31'h0, first_try}, 1);
    end
    idle();
    drain();
    chk("stream_count", pop_cycle.size(), 7);
    if (pop_cycle.size() == 7)
      chk("stream_no_gap", pop_cycle[6] - pop_cycle[0], 6);

    // Backpressure: two sets fill the pipe, the third must wait.
    out_ready = 1'b0;
    pop_cycle.delete();
    send(vecs[0]);
    send(vecs[1]);
    @(posedge clk); #1;
    partsum0 = vecs[2].p0; partsum1 = vecs[2].p1; partsum2 = vecs[2].p2;
    partsum3 = vecs[2].p3; neg = vecs[2].ng; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", {31'h0, in_ready}, 0);
      chk("bp_hold_valid", {31'h0, out_valid}, 1);
      chk("bp_hold_product", {16'h0, product}, 32'h000F);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", {31'h0, in_ready}, 1);
    exp_q.push_back(vecs[2].exp);
    idle();
    drain();
    chk("bp_count", pop_cycle.size(), 3);

    // Asynchronous reset with both stages full.
    out_ready = 1'b0;
    send(vecs[1]);
    send(vecs[2]);
    idle();
    @(negedge clk);
    chk("rst_pre_full_valid", {31'h0, out_valid}, 1);
    chk("rst_pre_in_ready", {31'h0, in_ready}, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", {31'h0, out_valid}, 0);
    chk("rst_async_product", {16'h0, product}, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    pop_cycle.delete();
    @(negedge clk);
    chk("rst_post_in_ready", {31'h0, in_ready}, 1);
    send(vecs[0]);
    idle();
    drain();
    repeat (4) @(negedge clk);
    chk("rst_no_stale", pop_cycle.size(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
